// File: rtl/lfsr_meas_gen_if.sv
// Control inputs and symbol/window outputs of the LFSR measurement generator.
// The generator drives outputs through master; the averaging path consumes them through slave.
interface lfsr_meas_gen_if #(
    parameter int LFSR_WID = 22
);
    logic                    run;
    logic                    restart;
    logic                    sym_clk_en;
    logic [1:0]              symbol;
    logic signed [17:0]      sym_val;
    logic                    clr_acc;
    logic                    meas_done;
    logic [7:0]              period_cnt;
    logic [LFSR_WID-1:0]     lfsr_state;

    modport master (
        input  run, restart,
        output sym_clk_en, symbol, sym_val, clr_acc, meas_done, period_cnt, lfsr_state
    );

    modport slave (
        output run, restart,
        input  sym_clk_en, symbol, sym_val, clr_acc, meas_done, period_cnt, lfsr_state
    );
endinterface

// File: rtl/lfsr_meas_gen.sv
// Symbol-rate divider, Fibonacci LFSR PAM-4 source and once-per-period
// measurement window (clr_acc / meas_done) for the error-averaging path.
module lfsr_meas_gen #(
    parameter int                     LFSR_WID = 22,
    parameter logic [LFSR_WID-1:0]    TAPS     = 22'h300000,
    parameter logic [LFSR_WID-1:0]    SEED     = 22'h000001,
    parameter int                     SYM_DIV  = 4
) (
    input  logic                 sys_clk,
    input  logic                 reset_n,
    lfsr_meas_gen_if.master      meas
);
    localparam int                DIV_W    = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SYM_DIV - 1);

    localparam logic signed [17:0] LVL_M3 = -18'sd98304;
    localparam logic signed [17:0] LVL_M1 = -18'sd32768;
    localparam logic signed [17:0] LVL_P1 =  18'sd32768;
    localparam logic signed [17:0] LVL_P3 =  18'sd98304;

    logic [LFSR_WID-1:0] lfsr,       lfsr_d;
    logic [DIV_W-1:0]    div_cnt,    div_d;
    logic                sym_en,     sym_en_d;
    logic                clr_acc,    clr_d;
    logic                meas_done,  meas_d;
    logic [7:0]          period_cnt, period_d;
    logic [LFSR_WID-1:0] lfsr_step;

    // An all-zero register would lock up; it steps back to SEED and counts as a period end.
    assign lfsr_step = (lfsr == '0) ? SEED : {lfsr[LFSR_WID-2:0], ^(lfsr & TAPS)};

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        lfsr_d   = lfsr;
        div_d    = div_cnt;
        sym_en_d = 1'b0;
        clr_d    = clr_acc;
        meas_d   = 1'b0;
        period_d = period_cnt;

        if (meas.restart) begin
            lfsr_d   = SEED;
            div_d    = '0;
            clr_d    = 1'b0;
            period_d = '0;
        end else if (meas.run) begin
            if (div_cnt == DIV_LAST) begin
                div_d    = '0;
                sym_en_d = 1'b1;
                lfsr_d   = lfsr_step;
                // Window decisions look at the value being loaded, so clr_acc
                // rises together with the SEED symbol.
                if (lfsr_step == SEED) begin
                    clr_d = 1'b1;
                    if (period_cnt != 8'hFF) period_d = period_cnt + 8'd1;
                end else if (clr_acc) begin
                    clr_d  = 1'b0;
                    meas_d = 1'b1;
                end
            end else begin
                div_d = div_cnt + DIV_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr       <= SEED;
            div_cnt    <= '0;
            sym_en     <= 1'b0;
            clr_acc    <= 1'b0;
            meas_done  <= 1'b0;
            period_cnt <= '0;
        end else begin
            lfsr       <= lfsr_d;
            div_cnt    <= div_d;
            sym_en     <= sym_en_d;
            clr_acc    <= clr_d;
            meas_done  <= meas_d;
            period_cnt <= period_d;
        end
    end

    always_comb begin
        unique case (lfsr[1:0])
            2'b00:   meas.sym_val = LVL_M3;
            2'b01:   meas.sym_val = LVL_M1;
            2'b10:   meas.sym_val = LVL_P1;
            default: meas.sym_val = LVL_P3;
        endcase
    end

    assign meas.sym_clk_en = sym_en;
    assign meas.symbol     = lfsr[1:0];
    assign meas.clr_acc    = clr_acc;
    assign meas.meas_done  = meas_done;
    assign meas.period_cnt = period_cnt;
    assign meas.lfsr_state = lfsr;
endmodule
